// File: rtl/time_keeper.sv
// Time-of-day counter (hh:mm:ss) driven by a clk-cycle prescaler, with
// button-driven hour/minute editing and a validated direct-load path.
module time_keeper #(
    parameter int CYCLES_PER_SEC = 100000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        set_time,
    input  logic [10:0] time_set_in,
    input  logic        mode_btn,
    input  logic        inc_btn,
    output logic [10:0] time_out,
    output logic [5:0]  sec_out,
    output logic        min_pulse,
    output logic        day_pulse,
    output logic [1:0]  edit_state,
    output logic        set_err
);

    localparam int PW = (CYCLES_PER_SEC > 2) ? $clog2(CYCLES_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CYCLES_PER_SEC - 1);

    typedef enum logic [1:0] {
        RUN       = 2'b00,
        EDIT_HOUR = 2'b01,
        EDIT_MIN  = 2'b10
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [5:0]    sec, sec_nxt;
    logic [5:0]    min, min_nxt;
    logic [4:0]    hour, hour_nxt;
    logic          min_pulse_nxt, day_pulse_nxt, set_err_nxt;

    logic [4:0] set_hour;
    logic [5:0] set_min;
    logic       set_ok;

    function automatic logic [5:0] wrap_inc60(input logic [5:0] v);
        return (v >= 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [4:0] wrap_inc24(input logic [4:0] v);
        return (v >= 5'd23) ? 5'd0 : v + 5'd1;
    endfunction

    assign set_hour = time_set_in[10:6];
    assign set_min  = time_set_in[5:0];
    assign set_ok   = (set_hour <= 5'd23) && (set_min <= 6'd59);

    // One priority chain decides the whole next state: a higher-priority
    // action in a cycle consumes it and everything below is dropped.
    always_comb begin
        state_nxt     = state;
        presc_nxt     = presc;
        sec_nxt       = sec;
        min_nxt       = min;
        hour_nxt      = hour;
        min_pulse_nxt = 1'b0;
        day_pulse_nxt = 1'b0;
        set_err_nxt   = 1'b0;

        if (set_time) begin
            if (set_ok) begin
                hour_nxt  = set_hour;
                min_nxt   = set_min;
                sec_nxt   = 6'd0;
                presc_nxt = '0;
                state_nxt = RUN;
            end else begin
                set_err_nxt = 1'b1;
            end
        end else if (mode_btn) begin
            case (state)
                RUN:       state_nxt = EDIT_HOUR;
                EDIT_HOUR: state_nxt = EDIT_MIN;
                EDIT_MIN: begin
                    state_nxt = RUN;
                    sec_nxt   = 6'd0;
                    presc_nxt = '0;
                end
                default:   state_nxt = RUN;
            endcase
        end else if (inc_btn && state != RUN) begin
            if (state == EDIT_HOUR)
                hour_nxt = wrap_inc24(hour);
            else if (state == EDIT_MIN)
                min_nxt = wrap_inc60(min);
        end else if (state == RUN && en) begin
            if (presc == PRESC_LAST) begin
                presc_nxt = '0;
                sec_nxt   = wrap_inc60(sec);
                if (sec == 6'd59) begin
                    min_nxt       = wrap_inc60(min);
                    min_pulse_nxt = 1'b1;
                    if (min == 6'd59) begin
                        hour_nxt = wrap_inc24(hour);
                        if (hour == 5'd23)
                            day_pulse_nxt = 1'b1;
                    end
                end
            end else begin
                presc_nxt = presc + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            presc     <= '0;
            sec       <= 6'd0;
            min       <= 6'd0;
            hour      <= 5'd0;
            min_pulse <= 1'b0;
            day_pulse <= 1'b0;
            set_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            presc     <= presc_nxt;
            sec       <= sec_nxt;
            min       <= min_nxt;
            hour      <= hour_nxt;
            min_pulse <= min_pulse_nxt;
            day_pulse <= day_pulse_nxt;
            set_err   <= set_err_nxt;
        end
    end

    assign time_out   = {hour, min};
    assign sec_out    = sec;
    assign edit_state = state;

endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 The module SHALL have parameter CYCLES_PER_SEC, default 100000000, meaning clk cycles per counted second (minimum 2).
REQ-002 The module SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 The module SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The module SHALL have port en  input  1  counting enable; low freezes timekeeping including the prescaler.
REQ-005 The module SHALL have port set_time  input  1  single-cycle load strobe for time_set_in.
REQ-006 The module SHALL have port time_set_in  input  11  load value {hour[4:0], min[5:0]}.
REQ-007 The module SHALL have port mode_btn  input  1  single-cycle pulse advancing the edit state.
REQ-008 The module SHALL have port inc_btn  input  1  single-cycle pulse incrementing the field under edit.
REQ-009 The module SHALL have port time_out  output  11  current time {hour[4:0], min[5:0]}, registered, alarm-compatible format.
REQ-010 The module SHALL have port sec_out  output  6  current seconds 0..59, registered.
REQ-011 The module SHALL have port min_pulse  output  1  one-cycle pulse on counted minute rollover.
REQ-012 The module SHALL have port day_pulse  output  1  one-cycle pulse on 23:59:59 -> 00:00:00.
REQ-013 The module SHALL have port edit_state  output  2  00 RUN, 01 EDIT_HOUR, 10 EDIT_MIN.
REQ-014 The module SHALL have port set_err  output  1  one-cycle pulse on rejected load.

Function
REQ-015 The FSM SHALL have states RUN, EDIT_HOUR, EDIT_MIN; mode_btn: RUN->EDIT_HOUR->EDIT_MIN->RUN.
REQ-016 Prescaler SHALL count 0..CYCLES_PER_SEC-1 only in RUN with en=1; at terminal count it wraps to 0 and the seconds field advances.
REQ-017 Carry chain SHALL be: sec 59->0 carries min; min 59->0 carries hour; hour 23->0 wraps, all in the same cycle.
REQ-018 min_pulse SHALL be high exactly in the cycle the rolled-over time_out is first visible; day_pulse likewise, coincident with min_pulse on the day wrap.
REQ-019 In EDIT_HOUR/EDIT_MIN, counting SHALL halt (prescaler and sec held); no min_pulse/day_pulse SHALL be generated.
REQ-020 inc_btn in EDIT_HOUR SHALL advance hour 23->0 with wrap and no carry; in EDIT_MIN, min 59->0 with no carry into hour; in RUN inc_btn is ignored.
REQ-021 Transition EDIT_MIN->RUN SHALL clear sec and prescaler to 0.
REQ-022 set_time with hour<=23 and min<=59 SHALL load hour/min next cycle, clear sec and prescaler, force state RUN; no min_pulse.
REQ-023 set_time with hour>23 or min>59 SHALL leave all state unchanged and pulse set_err for one cycle.
REQ-024 Priority per cycle SHALL be rst > set_time > mode_btn > inc_btn > counting; lower-priority inputs in the same cycle are discarded.
REQ-025 Simultaneous set_time and prescaler terminal count SHALL yield the loaded value with sec=0 (the tick is lost).
REQ-026 en deassertion SHALL hold the prescaler value; reassertion SHALL resume from it.

Reset
REQ-027 On rst=1 at a clock edge, time_out SHALL be 0, sec_out 0, prescaler 0, edit_state RUN, min_pulse/day_pulse/set_err 0, from any state including mid-edit.

Verification (CYCLES_PER_SEC=2)
REQ-028 Reset 1 cycle -> time_out=0, sec_out=0, edit_state=00, all pulses 0.
REQ-029 Load {23,59}, en=1, 120 cycles -> time_out=0, sec_out=0, min_pulse and day_pulse each high exactly one cycle, same cycle.
REQ-030 Load {24,10} -> set_err one cycle, time_out unchanged; load {8,60} -> same.
REQ-031 Time {22,15}: mode_btn, inc_btn x3 -> hour 23,0,1; min stays 15; sec frozen; mode_btn x2 -> RUN, sec_out=0.
REQ-032 en=0 for 20 cycles at {8,30} sec 10 -> outputs frozen; en=1 -> sec 11 after 2 cycles.
REQ-033 rst asserted in EDIT_MIN with set_time and inc_btn also high -> reset values next cycle, edit_state=00.
